// File: rtl/usb_keyboard_ascii_feeder_if.sv
// Bundles the ASCII byte stream and the keyboard-facing outputs of the ASCII feeder.
// A byte moves only on a clock edge where ascii_valid and ascii_ready are both high.
// The source holds ascii_data steady while ascii_valid=1 and ascii_ready=0.
interface usb_keyboard_ascii_feeder_if;
   logic [7:0]  ascii_data;
   logic        ascii_valid;
   logic        ascii_ready;
   logic [15:0] key_value;
   logic        key_request;
   logic        unsupported;
   logic        busy;
   logic [1:0]  state_dbg;

   modport master (
      output ascii_data, ascii_valid,
      input  ascii_ready, key_value, key_request, unsupported, busy, state_dbg
   );

   modport slave (
      input  ascii_data, ascii_valid,
      output ascii_ready, key_value, key_request, unsupported, busy, state_dbg
   );
endinterface

// File: rtl/usb_keyboard_ascii_feeder.sv
// Buffers ASCII bytes in a FIFO, translates each one to a HID {modifier,keycode} pair and
// issues paced key_request pulses so every press/release report pair completes first.
module usb_keyboard_ascii_feeder #(
   parameter int unsigned FIFO_DEPTH_LOG2 = 4,
   parameter int unsigned GAP_CYCLES      = 13000000
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         usb_rstn,
   usb_keyboard_ascii_feeder_if.slave   io
);
   localparam int unsigned A     = FIFO_DEPTH_LOG2;
   localparam int unsigned DEPTH = 1 << A;
   localparam int unsigned CW    = $clog2(GAP_CYCLES + 1);
   localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOOKUP = 2'd1,
      ST_ISSUE  = 2'd2,
      ST_GAP    = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [A:0]      wr_ptr_q, wr_ptr_d;
   logic [A:0]      rd_ptr_q, rd_ptr_d;
   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];
   logic [16:0]     map_q, map_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [15:0]     key_value_q, key_value_d;
   logic            key_request_q, key_request_d;
   logic            unsupported_q, unsupported_d;

   logic            empty;
   logic            full;
   logic            push;
   logic            pop;

   // Result is {mapped, modifier[7:0], usage[7:0]}; mapped=0 means the byte is dropped.
   function automatic logic [16:0] map_ascii(input logic [7:0] c);
      logic [16:0] r;
      r = 17'h0;
      if (c >= 8'h61 && c <= 8'h7A)      r = {1'b1, 8'h00, c - 8'h5D};
      else if (c >= 8'h41 && c <= 8'h5A) r = {1'b1, 8'h02, c - 8'h3D};
      else if (c >= 8'h31 && c <= 8'h39) r = {1'b1, 8'h00, c - 8'h13};
      else begin
         case (c)
            8'h30:   r = {1'b1, 8'h00, 8'h27};
            8'h0A:   r = {1'b1, 8'h00, 8'h28};
            8'h08:   r = {1'b1, 8'h00, 8'h2A};
            8'h09:   r = {1'b1, 8'h00, 8'h2B};
            8'h20:   r = {1'b1, 8'h00, 8'h2C};
            8'h2D:   r = {1'b1, 8'h00, 8'h2D};
            8'h5F:   r = {1'b1, 8'h02, 8'h2D};
            8'h3D:   r = {1'b1, 8'h00, 8'h2E};
            8'h2B:   r = {1'b1, 8'h02, 8'h2E};
            8'h3B:   r = {1'b1, 8'h00, 8'h33};
            8'h3A:   r = {1'b1, 8'h02, 8'h33};
            8'h2C:   r = {1'b1, 8'h00, 8'h36};
            8'h2E:   r = {1'b1, 8'h00, 8'h37};
            8'h2F:   r = {1'b1, 8'h00, 8'h38};
            8'h3F:   r = {1'b1, 8'h02, 8'h38};
            8'h21:   r = {1'b1, 8'h02, 8'h1E};
            default: r = 17'h0;
         endcase
      end
      return r;
   endfunction

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[A] != rd_ptr_q[A]) && (wr_ptr_q[A-1:0] == rd_ptr_q[A-1:0]);

   assign io.ascii_ready = usb_rstn & ~full;
   assign push           = io.ascii_valid & io.ascii_ready;

   always_comb begin
      state_d       = state_q;
      map_d         = map_q;
      cnt_d         = cnt_q;
      key_value_d   = key_value_q;
      key_request_d = 1'b0;
      unsupported_d = 1'b0;
      mem_d         = mem_q;
      pop           = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               map_d   = map_ascii(mem_q[rd_ptr_q[A-1:0]]);
               state_d = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            if (map_q[16]) begin
               key_value_d   = map_q[15:0];
               key_request_d = 1'b1;
               state_d       = ST_ISSUE;
            end else begin
               unsupported_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = GAP_LOAD;
            state_d = (GAP_CYCLES == 1) ? ST_IDLE : ST_GAP;
         end
         ST_GAP: begin
            // Leaving one cycle before the count would read zero keeps request spacing at GAP+2.
            if (cnt_q <= CNT_ONE) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (push) mem_d[wr_ptr_q[A-1:0]] = io.ascii_data;
      wr_ptr_d = wr_ptr_q + {{A{1'b0}}, push};
      rd_ptr_d = rd_ptr_q + {{A{1'b0}}, pop};

      if (!usb_rstn) begin
         state_d       = ST_IDLE;
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         cnt_d         = '0;
         key_request_d = 1'b0;
         unsupported_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         map_q         <= '0;
         cnt_q         <= '0;
         key_value_q   <= '0;
         key_request_q <= 1'b0;
         unsupported_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         map_q         <= map_d;
         cnt_q         <= cnt_d;
         key_value_q   <= key_value_d;
         key_request_q <= key_request_d;
         unsupported_q <= unsupported_d;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign io.key_value   = key_value_q;
   assign io.key_request = key_request_q;
   assign io.unsupported = unsupported_q;
   assign io.busy        = !empty || (state_q != ST_IDLE);
   assign io.state_dbg   = state_q;
endmodule
